// File: rtl/zmc_wb_port.sv
`default_nettype none
// ============================================================================
//  Module   : zmc_wb_port
//  Purpose  : Wishbone classic single-cycle bus master for the zmc datapath.
//             Runs one load/store per controller request, returns load data,
//             and aborts with an error if the slave fails to respond in time.
//  Revision : 1.0  initial release
// ============================================================================
module zmc_wb_port #(
  parameter int DATA_WL   = 16,
  parameter int ADR_WL    = 16,
  parameter int TO_CYCLES = 255,
  parameter int TO_WL     = 8
) (
  input  logic               clk,
  input  logic               a_reset_l,
  input  logic               req_in,
  input  logic               we_in,
  input  logic [ADR_WL-1:0]  adr_in,
  input  logic [DATA_WL-1:0] data_wr_in,
  output logic [DATA_WL-1:0] data_rd_out,
  output logic               done_out,
  output logic               err_out,
  output logic               busy_out,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [ADR_WL-1:0]  wb_adr_o,
  output logic [DATA_WL-1:0] wb_dat_o,
  input  logic [DATA_WL-1:0] wb_dat_i,
  input  logic               wb_ack_i,
  input  logic               wb_err_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter value seen on the last BUS cycle that is still allowed to wait.
  localparam logic [TO_WL-1:0] TO_LAST = TO_WL'(TO_CYCLES - 1);
  localparam logic [TO_WL-1:0] CNT_MAX = {TO_WL{1'b1}};
  localparam logic [TO_WL-1:0] CNT_ONE = TO_WL'(1);

  state_t               state_q, state_d;
  logic [TO_WL-1:0]     cnt_q,   cnt_d;
  logic                 cyc_q,   cyc_d;
  logic                 we_q,    we_d;
  logic [ADR_WL-1:0]    adr_q,   adr_d;
  logic [DATA_WL-1:0]   dat_q,   dat_d;
  logic [DATA_WL-1:0]   rd_q,    rd_d;
  logic                 done_q,  done_d;
  logic                 err_q,   err_d;
  logic                 busy_q,  busy_d;

  // Next-state and next-output logic; done/err are single-cycle pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        cyc_d  = 1'b0;
        busy_d = 1'b0;
        if (req_in) begin
          we_d    = we_in;
          adr_d   = adr_in;
          dat_d   = data_wr_in;
          cyc_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end

      S_BUS: begin
        if (wb_err_i) begin
          // Error wins over a simultaneous ack; read data is discarded.
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (wb_ack_i) begin
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) begin
            rd_d = wb_dat_i;
          end
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          // Slave never answered: abort the cycle as a bus error.
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears the bus cycle without a clock.
  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign data_rd_out = rd_q;
  assign done_out    = done_q;
  assign err_out     = err_q;
  assign busy_out    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_zmc_wb_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zmc_wb_port
//  Purpose  : Self-checking bench for zmc_wb_port: directed scenarios plus
//             randomized traffic against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_zmc_wb_port;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 4;

  logic          clk;
  logic          a_reset_l;
  logic          req_in, we_in;
  logic [AW-1:0] adr_in;
  logic [DW-1:0] data_wr_in;
  logic [DW-1:0] data_rd_out;
  logic          done_out, err_out, busy_out;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i, wb_err_i;

  int n_checks = 0;
  int n_errors = 0;

  zmc_wb_port #(
    .DATA_WL   (DW),
    .ADR_WL    (AW),
    .TO_CYCLES (TO),
    .TO_WL     (8)
  ) dut (
    .clk         (clk),
    .a_reset_l   (a_reset_l),
    .req_in      (req_in),
    .we_in       (we_in),
    .adr_in      (adr_in),
    .data_wr_in  (data_wr_in),
    .data_rd_out (data_rd_out),
    .done_out    (done_out),
    .err_out     (err_out),
    .busy_out    (busy_out),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // Transaction view: a request opens a transaction; it occupies the bus
  // until the slave answers or TO bus cycles elapse, then spends one
  // reporting cycle before the port is free again.
  bit            m_open;      // transaction in progress (bus or report)
  bit            m_on_bus;    // still waiting for the slave
  int            m_bus_cycles;
  bit            m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat;
  logic [DW-1:0] m_rd;
  bit            m_done, m_err;

  always @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      m_open = 0; m_on_bus = 0; m_bus_cycles = 0;
      m_we = 0; m_adr = '0; m_dat = '0; m_rd = '0;
      m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_on_bus) begin
        m_bus_cycles = m_bus_cycles + 1;
        if (wb_err_i) begin
          m_on_bus = 0; m_done = 1; m_err = 1;
        end else if (wb_ack_i) begin
          m_on_bus = 0; m_done = 1;
          if (!m_we) m_rd = wb_dat_i;
        end else if (m_bus_cycles >= TO) begin
          m_on_bus = 0; m_done = 1; m_err = 1;
        end
      end else if (m_open) begin
        m_open = 0;
      end else if (req_in) begin
        m_open = 1; m_on_bus = 1; m_bus_cycles = 0;
        m_we = we_in; m_adr = adr_in; m_dat = data_wr_in;
      end
    end
  end

  // Compare process: every falling edge while out of reset.
  always @(negedge clk) begin
    if (a_reset_l) begin
      logic [53:0] act, exp;
      act = {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, data_rd_out,
             done_out, err_out, busy_out};
      exp = {m_on_bus, m_on_bus, m_we, m_adr, m_dat, m_rd,
             m_done, m_err, m_open};
      n_checks++;
      if (act !== exp) begin
        n_errors++;
        $display("FAIL model_cmp t=%0t got cyc/stb/we/adr/dato/rd/done/err/busy=%h expected %h",
                 $time, act, exp);
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // One request; slave responds on bus cycle resp_at (0 = never).
  task automatic txn(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                     input int resp_at, input bit with_err, input logic [DW-1:0] rdat,
                     input bit hold_req,
                     output int ncyc, output int nbusy, output int ndone,
                     output int nerr, output logic [DW-1:0] rd_at_done);
    bit finished;
    ncyc = 0; nbusy = 0; ndone = 0; nerr = 0; rd_at_done = '0;
    finished = 0;
    @(negedge clk); #1;
    req_in = 1; we_in = we; adr_in = adr; data_wr_in = dat;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (wb_cyc_o) ncyc++;
      if (busy_out) nbusy++;
      if (done_out) begin
        ndone++;
        if (err_out) nerr++;
        rd_at_done = data_rd_out;
      end
      if (!busy_out && c > 0) begin
        finished = 1;
        break;
      end
      #1;
      req_in   = hold_req;
      wb_ack_i = 0;
      wb_err_i = 0;
      if (wb_cyc_o && ncyc == resp_at) begin
        wb_ack_i = 1;
        wb_err_i = with_err;
        wb_dat_i = rdat;
      end
    end
    if (!finished) chk("txn_bound", 0, 1);
    #1;
    wb_ack_i = 0;
    wb_err_i = 0;
  endtask

  // ---------------------------------------------------------------- stimulus
  int nc, nb, nd, ne;
  logic [DW-1:0] rdd;

  initial begin
    a_reset_l = 0;
    req_in = 0; we_in = 0; adr_in = '0; data_wr_in = '0;
    wb_dat_i = '0; wb_ack_i = 0; wb_err_i = 0;
    repeat (3) @(negedge clk);
    #1 a_reset_l = 1;
    @(negedge clk);
    chk("reset_cyc",  {31'd0, wb_cyc_o}, 0);
    chk("reset_busy", {31'd0, busy_out}, 0);
    chk("reset_rd",   {16'd0, data_rd_out}, 0);

    // Store, zero-wait slave
    txn(1, 16'h0040, 16'hBEEF, 1, 0, 16'h0000, 0, nc, nb, nd, ne, rdd);
    chk("store_cyc_cycles", nc, 1);
    chk("store_busy_cycles", nb, 2);
    chk("store_done", nd, 1);
    chk("store_err", ne, 0);
    chk("store_adr", {16'd0, wb_adr_o}, 32'h0040);
    chk("store_dat", {16'd0, wb_dat_o}, 32'hBEEF);
    chk("store_we",  {31'd0, wb_we_o}, 1);

    // Load, 3 wait states
    txn(0, 16'h1234, 16'h0000, 4, 0, 16'hA5C3, 0, nc, nb, nd, ne, rdd);
    chk("load_cyc_cycles", nc, 4);
    chk("load_busy_cycles", nb, 5);
    chk("load_rd_at_done", {16'd0, rdd}, 32'hA5C3);
    @(negedge clk);
    chk("load_rd_held", {16'd0, data_rd_out}, 32'hA5C3);

    // Error with ack also high: read data discarded
    txn(0, 16'h2000, 16'h0000, 1, 1, 16'hFFFF, 0, nc, nb, nd, ne, rdd);
    chk("err_done", nd, 1);
    chk("err_flag", ne, 1);
    chk("err_rd_kept", {16'd0, data_rd_out}, 32'hA5C3);

    // Timeout: slave silent
    txn(0, 16'h3000, 16'h0000, 0, 0, 16'h0000, 0, nc, nb, nd, ne, rdd);
    chk("to_cyc_cycles", nc, TO);
    chk("to_err", ne, 1);
    chk("to_rd_kept", {16'd0, data_rd_out}, 32'hA5C3);
    txn(0, 16'h3002, 16'h0000, 2, 0, 16'h1357, 0, nc, nb, nd, ne, rdd);
    chk("after_to_ok", ne, 0);
    chk("after_to_rd", {16'd0, rdd}, 32'h1357);

    // Request held high through BUS and DONE
    txn(1, 16'h4000, 16'h0101, 2, 0, 16'h0000, 1, nc, nb, nd, ne, rdd);
    chk("hold_single_done", nd, 1);
    @(negedge clk);
    chk("hold_next_starts", {31'd0, wb_cyc_o}, 1);
    #1 req_in = 0; wb_ack_i = 1;
    @(negedge clk);
    chk("hold_next_done", {31'd0, done_out}, 1);
    #1 wb_ack_i = 0;
    @(negedge clk);

    // Stray ack while idle
    #1 wb_ack_i = 1; wb_err_i = 1;
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_out) nd++;
    end
    #1 wb_ack_i = 0; wb_err_i = 0;
    chk("stray_no_done", nd, 0);

    // Reset in the middle of a bus cycle
    @(negedge clk); #1;
    req_in = 1; we_in = 0; adr_in = 16'h5555;
    @(negedge clk); #1 req_in = 0;
    @(negedge clk);
    chk("rst_pre_cyc", {31'd0, wb_cyc_o}, 1);
    #2 a_reset_l = 0;
    #1;
    chk("rst_async_cyc", {30'd0, wb_cyc_o, wb_stb_o}, 0);
    chk("rst_outputs", {29'd0, done_out, busy_out, err_out}, 0);
    chk("rst_rd", {16'd0, data_rd_out}, 0);
    chk("rst_adr", {16'd0, wb_adr_o}, 0);
    @(negedge clk); #3 a_reset_l = 1;
    txn(0, 16'h6000, 16'h0000, 1, 0, 16'h2468, 0, nc, nb, nd, ne, rdd);
    chk("post_rst_rd", {16'd0, rdd}, 32'h2468);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 800; i++) begin
      @(negedge clk); #1;
      req_in     = ($urandom_range(0, 3) == 0);
      we_in      = $urandom_range(0, 1);
      adr_in     = AW'($urandom);
      data_wr_in = DW'($urandom);
      wb_ack_i   = ($urandom_range(0, 2) == 0);
      wb_err_i   = ($urandom_range(0, 15) == 0);
      wb_dat_i   = DW'($urandom);
    end
    @(negedge clk); #1;
    req_in = 0; wb_ack_i = 0; wb_err_i = 0;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
